// File: rtl/fpu_wb_arbiter_if.sv
// fpu_wb_arbiter_if: result ports, write port, scoreboard and flag signals of the FP write-back arbiter.
interface fpu_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FLAG_WIDTH = 5
);
    logic                     l_valid_i;
    logic [ADDR_WIDTH-1:0]    l_rd_addr_i;
    logic [DATA_WIDTH-1:0]    l_rd_data_i;
    logic                     a_valid_i;
    logic                     a_ready_o;
    logic [ADDR_WIDTH-1:0]    a_rd_addr_i;
    logic [DATA_WIDTH-1:0]    a_rd_data_i;
    logic [FLAG_WIDTH-1:0]    a_fflags_i;
    logic                     b_valid_i;
    logic                     b_ready_o;
    logic [ADDR_WIDTH-1:0]    b_rd_addr_i;
    logic [DATA_WIDTH-1:0]    b_rd_data_i;
    logic [FLAG_WIDTH-1:0]    b_fflags_i;
    logic                     iss_valid_i;
    logic [ADDR_WIDTH-1:0]    iss_rd_addr_i;
    logic                     rd_wren_o;
    logic [ADDR_WIDTH-1:0]    rd_addr_o;
    logic [DATA_WIDTH-1:0]    rd_data_o;
    logic [2**ADDR_WIDTH-1:0] busy_o;
    logic                     fflags_clr_i;
    logic [FLAG_WIDTH-1:0]    fflags_o;
    modport slave (
        input  l_valid_i, l_rd_addr_i, l_rd_data_i,
        input  a_valid_i, a_rd_addr_i, a_rd_data_i, a_fflags_i,
        input  b_valid_i, b_rd_addr_i, b_rd_data_i, b_fflags_i,
        input  iss_valid_i, iss_rd_addr_i, fflags_clr_i,
        output a_ready_o, b_ready_o, rd_wren_o, rd_addr_o, rd_data_o, busy_o, fflags_o
    );
    modport master (
        output l_valid_i, l_rd_addr_i, l_rd_data_i,
        output a_valid_i, a_rd_addr_i, a_rd_data_i, a_fflags_i,
        output b_valid_i, b_rd_addr_i, b_rd_data_i, b_fflags_i,
        output iss_valid_i, iss_rd_addr_i, fflags_clr_i,
        input  a_ready_o, b_ready_o, rd_wren_o, rd_addr_o, rd_data_o, busy_o, fflags_o
    );
endinterface

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: FP register-file write-back arbiter (load > round-robin FMA/divsqrt),
// with a pending-write scoreboard and sticky exception flags.
module fpu_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FLAG_WIDTH = 5
) (
    input logic              clk_i,
    input logic              rst_i,
    fpu_wb_arbiter_if.slave  bus
);
    localparam int NREG = 2**ADDR_WIDTH;
    logic                  ptr_b;
    logic                  grant_a;
    logic                  grant_b;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [FLAG_WIDTH-1:0] win_flags;
    logic [NREG-1:0]       set_v;
    logic [NREG-1:0]       clr_v;
    always_comb begin
        grant_a   = !rst_i && !bus.l_valid_i && bus.a_valid_i && (!bus.b_valid_i || !ptr_b);
        grant_b   = !rst_i && !bus.l_valid_i && bus.b_valid_i && (!bus.a_valid_i || ptr_b);
        win_addr  = bus.l_valid_i ? bus.l_rd_addr_i : grant_a ? bus.a_rd_addr_i : bus.b_rd_addr_i;
        win_data  = bus.l_valid_i ? bus.l_rd_data_i : grant_a ? bus.a_rd_data_i : bus.b_rd_data_i;
        win_flags = grant_a ? bus.a_fflags_i : grant_b ? bus.b_fflags_i : '0;
        // x0 is hardwired: the handshake completes but nothing is written
        wr_en     = (bus.l_valid_i || grant_a || grant_b) && win_addr != '0;
        set_v     = (bus.iss_valid_i && bus.iss_rd_addr_i != '0) ? NREG'(1) << bus.iss_rd_addr_i : '0;
        clr_v     = bus.rd_wren_o ? NREG'(1) << bus.rd_addr_o : '0;
    end
    assign bus.a_ready_o = grant_a;
    assign bus.b_ready_o = grant_b;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_b         <= 1'b0;
            bus.rd_wren_o <= 1'b0;
            bus.rd_addr_o <= '0;
            bus.rd_data_o <= '0;
            bus.busy_o    <= '0;
            bus.fflags_o  <= '0;
        end else begin
            bus.rd_wren_o <= wr_en;
            if (wr_en) begin
                bus.rd_addr_o <= win_addr;
                bus.rd_data_o <= win_data;
            end
            if (grant_a || grant_b)
                ptr_b <= !ptr_b;
            // a younger issue to the committing register keeps it busy
            bus.busy_o   <= (bus.busy_o & ~clr_v) | set_v;
            bus.fflags_o <= (bus.fflags_clr_i ? '0 : bus.fflags_o) | win_flags;
        end
    end
endmodule

// File: doc/fpu_wb_arbiter.md
Name: fpu_wb_arbiter

Overview:
- Write-back side of the floating-point register file. Collects results from the FP load path, the pipelined FMA unit and the iterative div/sqrt unit, and arbitrates between them.
- Drives exactly one registered write per cycle into the register file's rd write port.
- Maintains a pending-write scoreboard so issue logic can stall on RAW/WAW hazards.
- Accumulates sticky IEEE exception flags (fflags) for the CSR block.

Parameters:
DATA_WIDTH, 32, width of FP register data
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
FLAG_WIDTH, 5, exception flag width (NV,DZ,OF,UF,NX)

Ports:
clk_i  in  1  positive-edge clock
rst_i  in  1  reset, asynchronous, active-high
l_valid_i  in  1  FP load result valid (no backpressure)
l_rd_addr_i  in  ADDR_WIDTH  load destination
l_rd_data_i  in  DATA_WIDTH  load data
a_valid_i  in  1  FMA result valid
a_ready_o  out  1  FMA result accepted
a_rd_addr_i  in  ADDR_WIDTH  FMA destination
a_rd_data_i  in  DATA_WIDTH  FMA result
a_fflags_i  in  FLAG_WIDTH  FMA exception flags
b_valid_i  in  1  div/sqrt result valid
b_ready_o  out  1  div/sqrt result accepted
b_rd_addr_i  in  ADDR_WIDTH  div/sqrt destination
b_rd_data_i  in  DATA_WIDTH  div/sqrt result
b_fflags_i  in  FLAG_WIDTH  div/sqrt exception flags
iss_valid_i  in  1  an FP instruction writing rd is issued
iss_rd_addr_i  in  ADDR_WIDTH  its destination
rd_wren_o  out  1  register file write enable
rd_addr_o  out  ADDR_WIDTH  register file write address
rd_data_o  out  DATA_WIDTH  register file write data
busy_o  out  2**ADDR_WIDTH  per-register pending-write bit
fflags_clr_i  in  1  clear sticky flags (CSR write)
fflags_o  out  FLAG_WIDTH  sticky accumulated flags

Behaviour:
- Reset (rst_i high, asynchronous):
  - rd_wren_o, rd_addr_o, rd_data_o, busy_o and fflags_o all forced to 0.
  - Round-robin pointer set to A.
  - a_ready_o and b_ready_o are 0 while rst_i is high.
  - Results presented during reset are discarded; no write occurs in the first cycle after deassertion.
- Grant (combinational, per cycle):
  - Load has absolute priority: l_valid_i=1 forces a_ready_o=b_ready_o=0.
  - Otherwise a lone valid among A/B gets ready=1.
  - If both A and B are valid, the grant goes to the round-robin pointer's port; the other port's ready is 0.
  - Pointer flips to the other port only after an A/B grant occurs. It is unchanged in load cycles and idle cycles.
  - a_ready_o / b_ready_o never depend on the port's own valid except through this arbitration. A port that is not granted must hold valid, addr, data and flags stable (standard valid/ready).
- Output stage:
  - The winning result is captured at the clock edge.
  - rd_wren_o/rd_addr_o/rd_data_o are registered: accept at edge k, write visible in the cycle after k, committed to the register file at edge k+1. Latency is 1 cycle.
  - With no grant, rd_wren_o=0; rd_addr_o and rd_data_o hold their previous values.
  - Destination address 0 is never written: the grant and handshake still complete, but rd_wren_o stays 0 and no flags are dropped.
- Scoreboard:
  - iss_valid_i with addr≠0 sets busy_o[addr] at the edge.
  - busy_o[rd_addr_o] clears at the edge where rd_wren_o=1.
  - Set and clear on the same address at the same edge: set wins, because the new issue is younger.
  - iss_valid_i to addr 0 is ignored; busy_o[0] is constantly 0.
  - Clear for an address that is not busy is a no-op.
- fflags:
  - At an A/B grant edge: fflags_o <= fflags_o | granted flags.
  - Loads carry no flags.
  - fflags_clr_i at the same edge as a grant: fflags_o <= granted flags only. fflags_clr_i alone clears to 0.
  - Flags from an addr-0 result are still accumulated.
- Throughput: one write per cycle sustained. With a continuous load stream, A and B are starved by design; the issue logic prevents this.

Test Plan:
- Reset: assert rst_i mid-write with a_valid_i=1, addr=3 -> rd_wren_o, busy_o and fflags_o read 0 immediately; after release, the first write appears one cycle after the first accept.
- Single FMA: a_valid_i=1, addr=7, data=0x3F800000, flags=5'b00001 -> a_ready_o=1; next cycle rd_wren_o=1, rd_addr_o=7, rd_data_o=0x3F800000; fflags_o=00001 from that cycle.
- Contention: A (addr 1) and B (addr 2) held valid together for 4 cycles, pointer at A -> writes in order 1,2,1,2; the non-granted ready is 0 each cycle.
- Load priority: l_valid_i=1 (addr 4) with a_valid_i=1 (addr 5) -> a_ready_o=0; write 4, then 5 the following cycle.
- Scoreboard: issue addr 9 -> busy_o[9]=1; A write to 9 -> bit clears at the commit edge; a fresh issue to 9 on that same edge -> bit stays 1. Issue to addr 0 -> busy_o[0] remains 0, and an A result to addr 0 produces rd_wren_o=0.
- Flags: B result with flags 10000 accumulates over an existing 00001 -> fflags_o=10001; fflags_clr_i on the same edge as an A grant with flags 00100 -> fflags_o=00100.
